// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the gated frequency meter.
package freq_meter_pkg;

    localparam int SYS_CLK_HZ       = 100_000_000;
    localparam int DEF_GATE_CYCLES  = 100_000_000;
    localparam int DEF_CNT_W        = 27;
    localparam int DEF_SYNC_STAGES  = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    // Width of a counter that runs 0..cycles-1.
    function automatic int gate_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous input plus a rising-edge pulse.
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic D_ASYNC,
    output logic Q_SYNC,
    output logic RISE
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], D_ASYNC};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign Q_SYNC = sync_q[SYNC_STAGES-1];
    assign RISE   = Q_SYNC & ~sync_prev;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of SIG_IN over a fixed window.
//   state      | meaning
//   ST_IDLE    | disabled, counters cleared, GATE low
//   ST_DISCARD | warm-up window, count thrown away
//   ST_MEASURE | counting window, result published at terminal count
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             SIG_IN,
    output logic [CNT_W-1:0] FREQ,
    output logic             VALID,
    output logic             OVF,
    output logic             GATE
);

    localparam int               GW        = gate_w(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat;
    logic             sig_sync;
    logic             sig_rise;
    logic             terminal;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CLK     (CLK),
        .RST     (RST),
        .D_ASYNC (SIG_IN),
        .Q_SYNC  (sig_sync),
        .RISE    (sig_rise)
    );

    assign terminal = (gate_cnt == GATE_LAST);

    // Count including this cycle's edge, so a terminal-cycle edge lands in the closing window.
    always_comb begin
        cnt_next = edge_cnt;
        sat_next = sat;
        if (sig_rise) begin
            if (edge_cnt == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            FREQ     <= '0;
            VALID    <= 1'b0;
            OVF      <= 1'b0;
            GATE     <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (!EN) begin
                state    <= ST_IDLE;
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
                GATE     <= 1'b0;
            end else begin
                case (state)
                    ST_DISCARD, ST_MEASURE: begin
                        GATE <= 1'b1;
                        if (terminal) begin
                            state    <= ST_MEASURE;
                            gate_cnt <= '0;
                            edge_cnt <= '0;
                            sat      <= 1'b0;
                            if (state == ST_MEASURE) begin
                                FREQ  <= cnt_next;
                                OVF   <= sat_next;
                                VALID <= 1'b1;
                            end
                        end else begin
                            gate_cnt <= gate_cnt + 1'b1;
                            edge_cnt <= cnt_next;
                            sat      <= sat_next;
                        end
                    end
                    default: begin
                        state    <= ST_DISCARD;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                        GATE     <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic unused_sync;
    assign unused_sync = sig_sync;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 27-bit and a 3-bit instance share all stimulus.
module tb_freq_meter;

    localparam int GC = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        sig = 1'b0;
    logic        lvl = 1'b0;
    int          per = 6;
    int          ph  = 0;
    int          cyc = 0;

    logic [26:0] freq;
    logic        valid, ovf, gate;
    logic [2:0]  freq3;
    logic        valid3, ovf3, gate3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        int freq;
        bit ovf;
    } exp_t;

    exp_t q27[$];
    exp_t q3[$];

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(27), .SYNC_STAGES(2)) dut (
        .CLK(clk), .RST(rst), .EN(en), .SIG_IN(sig),
        .FREQ(freq), .VALID(valid), .OVF(ovf), .GATE(gate)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(3), .SYNC_STAGES(2)) dut3 (
        .CLK(clk), .RST(rst), .EN(en), .SIG_IN(sig),
        .FREQ(freq3), .VALID(valid3), .OVF(ovf3), .GATE(gate3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // per==0 holds SIG_IN at lvl; otherwise a square wave of period per cycles.
    always begin
        @(posedge clk);
        #2;
        if (per == 0) begin
            sig = lvl;
        end else begin
            ph  = (ph + 1 >= per) ? 0 : ph + 1;
            sig = (ph < per / 2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_win(input int vc, input int n);
        q27.push_back('{vc, n, 1'b0});
        q3.push_back('{vc, (n > 7) ? 7 : n, n > 7});
    endtask

    task automatic en_on(output int c);
        en = 1'b1;
        c  = cyc;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_freq"},  freq,   0);
        chk({tag, "_valid"}, valid,  0);
        chk({tag, "_ovf"},   ovf,    0);
        chk({tag, "_gate"},  gate,   0);
        chk({tag, "_freq3"}, freq3,  0);
        chk({tag, "_gate3"}, gate3,  0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            chk("dut27_valid_pending", q27.size() > 0, 1);
            if (q27.size() > 0) begin
                e = q27.pop_front();
                chk("dut27_valid_cyc", cyc, e.cyc);
                chk("dut27_freq", freq, e.freq);
                chk("dut27_ovf", ovf, e.ovf);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid3 === 1'b1) begin
            chk("dut3_valid_pending", q3.size() > 0, 1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("dut3_valid_cyc", cyc, e.cyc);
                chk("dut3_freq", freq3, e.freq);
                chk("dut3_ovf", ovf3, e.ovf);
            end
        end
    end

    initial begin
        int c;

        // Reset held with EN high and SIG_IN toggling.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_outputs_zero("reset_hold");
        end
        rst = 1'b0;
        en  = 1'b0;
        per = 10;
        repeat (5) tick();

        // Period 10: DISCARD window, then three published windows.
        en_on(c);
        push_win(c + 201, 10);
        push_win(c + 301, 10);
        push_win(c + 401, 10);
        wait_until(c + 60);
        chk("discard_gate", gate, 1);
        // EN dropped at gate_cnt=50 of MEASURE.
        wait_until(c + 451);
        en = 1'b0;
        tick();
        chk("en_drop_gate", gate, 0);
        chk("en_drop_valid", valid, 0);
        chk("en_drop_freq_hold", freq, 10);
        chk("en_drop_freq3_hold", freq3, 7);
        chk("en_drop_ovf3_hold", ovf3, 1);
        wait_until(c + 520);
        en_on(c);
        push_win(c + 201, 10);
        wait_until(c + 250);
        en = 1'b0;

        // Saturation on the 3-bit instance, then recovery.
        per = 4;
        repeat (5) tick();
        en_on(c);
        push_win(c + 201, 25);
        push_win(c + 301, 25);
        wait_until(c + 350);
        en  = 1'b0;
        per = 20;
        repeat (5) tick();
        en_on(c);
        push_win(c + 201, 5);
        push_win(c + 301, 5);
        wait_until(c + 350);
        en = 1'b0;

        // Single rises landing on the terminal cycle and on cycle 0 of a window.
        per = 0;
        lvl = 1'b0;
        repeat (5) tick();
        en_on(c);
        push_win(c + 201, 1);
        push_win(c + 301, 0);
        push_win(c + 401, 1);
        wait_until(c + 198);
        lvl = 1'b1;
        wait_until(c + 251);
        lvl = 1'b0;
        wait_until(c + 299);
        lvl = 1'b1;
        wait_until(c + 450);
        en  = 1'b0;
        lvl = 1'b0;
        repeat (5) tick();

        // RST pulse mid-window, then a fresh sequence with SIG_IN stuck high.
        per = 10;
        repeat (5) tick();
        en_on(c);
        wait_until(c + 151);
        rst = 1'b1;
        per = 0;
        lvl = 1'b1;
        tick();
        chk_outputs_zero("mid_reset");
        chk("mid_reset_ovf3", ovf3, 0);
        rst = 1'b0;
        push_win(c + 353, 0);
        push_win(c + 453, 0);
        wait_until(c + 470);
        en = 1'b0;
        repeat (5) tick();

        chk("dut27_queue_drained", q27.size(), 0);
        chk("dut3_queue_drained", q3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
